// File: rtl/nco_pkg.sv
// nco_pkg: shared types, constants and table generator for the quadrature NCO.
// Contents:
//   nco_state_e      - FCW update state (ST_IDLE / ST_PENDING)
//   QUAD_*_BIT       - which bit of the 2-bit quadrant code mirrors or negates
//   LFSR_SEED/TAPS   - seed and feedback taps of the phase-dither LFSR
//   tbl_entry()      - quarter-wave table value, evaluated at elaboration time
package nco_pkg;

    typedef enum logic {ST_IDLE, ST_PENDING} nco_state_e;

    // Quadrant code is the top two phase bits.
    // Bit 0 set means the quarter is read backwards.
    // Bit 1 set means the lower half-wave, so the magnitude is negated.
    localparam int QUAD_MIRROR_BIT = 0;
    localparam int QUAD_NEG_BIT    = 1;

    // x^16 + x^14 + x^13 + x^11 + 1, taken from bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // pi in Q28 fixed point.
    localparam longint PI_Q28 = 64'sd843314857;

    // round(amp * sin(pi*(2*idx+1)/2^(addr_bits+2))), where amp = 2^(data_bits-1)-1.
    // Integer Taylor series in Q28, so no real arithmetic is needed at elaboration.
    // The angle stays below pi/2, where eight terms give far more precision than
    // any practical output width needs.
    function automatic int tbl_entry(input int idx, input int addr_bits, input int data_bits);
        longint th;
        longint th2;
        longint term;
        longint sum;
        longint amp;
        th   = (PI_Q28 * longint'(2 * idx + 1)) >>> (addr_bits + 2);
        th2  = (th * th) >>> 28;
        term = th;
        sum  = th;
        for (int k = 1; k < 8; k++) begin
            term = -((term * th2) >>> 28) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) << (data_bits - 1)) - longint'(1);
        return int'((amp * sum + (longint'(1) << 27)) >>> 28);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: quarter-wave sine ROM with quadrant fold and negate (combinational).
// Ports:
//   i_phase [LUT_ADDR_BITS+2]  - phase; the top 2 bits give the quadrant
//   o_data  [DATA_BITS_OUT]    - signed sine of i_phase
import nco_pkg::*;

module nco_quarter_lut #(
    parameter int LUT_ADDR_BITS = 6,
    parameter int DATA_BITS_OUT = 4
) (
    input  logic        [LUT_ADDR_BITS+1:0] i_phase,
    output logic signed [DATA_BITS_OUT-1:0] o_data
);

    localparam int DEPTH = 1 << LUT_ADDR_BITS;

    logic signed [DATA_BITS_OUT-1:0] w_rom [DEPTH];
    logic        [1:0]               w_q;
    logic        [LUT_ADDR_BITS-1:0] w_a;
    logic        [LUT_ADDR_BITS-1:0] w_idx;
    logic signed [DATA_BITS_OUT-1:0] w_mag;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int V = tbl_entry(g, LUT_ADDR_BITS, DATA_BITS_OUT);
        assign w_rom[g] = DATA_BITS_OUT'(V);
    end

    assign w_q    = i_phase[LUT_ADDR_BITS+1 -: 2];
    assign w_a    = i_phase[LUT_ADDR_BITS-1:0];
    assign w_idx  = w_q[QUAD_MIRROR_BIT] ? ~w_a : w_a;
    assign w_mag  = w_rom[w_idx];
    // Table entries are at most 2^(N-1)-1 in magnitude, so negation cannot overflow.
    assign o_data = w_q[QUAD_NEG_BIT] ? -w_mag : w_mag;

endmodule

// File: rtl/nco_quad.sv
// nco_quad: parametrised quadrature NCO with FCW handshake, phase offset, sync and wrap strobe.
// Ports:
//   i_clk, i_rst_n         - clock and synchronous active-low reset
//   i_ena                  - advance enable; low freezes the accumulator and pipeline
//   i_fcw, i_fcw_valid     - offered frequency word; o_fcw_ready accepts it
//   i_phase_ofs            - static phase offset, MSB-aligned to the truncated phase
//   i_sync                 - clear the accumulator; also applies a pending FCW
//   o_sin_out, o_cos_out   - signed quadrature samples
//   o_out_valid            - high from the third enabled edge after reset
//   o_wrap                 - one-cycle pulse on accumulator carry-out
// Optional: define NCO_QUAD_PHASE_DITHER_EN to add LFSR dither below the truncation point.
import nco_pkg::*;

module nco_quad #(
    parameter int FCW_BITS       = 16,
    parameter int PHASE_ACC_BITS = 20,
    parameter int LUT_ADDR_BITS  = 6,
    parameter int DATA_BITS_OUT  = 4,
    parameter int PHASE_OFS_BITS = 8,
    parameter int UPDATE_ON_WRAP = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_ena,
    input  logic        [FCW_BITS-1:0]       i_fcw,
    input  logic                             i_fcw_valid,
    output logic                             o_fcw_ready,
    input  logic        [PHASE_OFS_BITS-1:0] i_phase_ofs,
    input  logic                             i_sync,
    output logic signed [DATA_BITS_OUT-1:0]  o_sin_out,
    output logic signed [DATA_BITS_OUT-1:0]  o_cos_out,
    output logic                             o_out_valid,
    output logic                             o_wrap
);

    localparam int              PW  = LUT_ADDR_BITS + 2;
    localparam int              AW1 = PHASE_ACC_BITS + 1;
    localparam logic [PW-1:0]   QTR = PW'(1) << LUT_ADDR_BITS;

    nco_state_e                      r_state;
    logic                            r_fcw_ready;
    logic        [FCW_BITS-1:0]      r_fcw_active;
    logic        [FCW_BITS-1:0]      r_fcw_pend;
    logic        [PHASE_ACC_BITS-1:0] r_acc;
    logic        [PW-1:0]            r_ph;
    logic        [1:0]               r_vcnt;
    logic                            r_valid;
    logic                            r_wrap;
    logic signed [DATA_BITS_OUT-1:0] r_sin;
    logic signed [DATA_BITS_OUT-1:0] r_cos;

    logic        [PHASE_ACC_BITS:0]  w_sum;
    logic                            w_carry;
    logic                            w_xfer;
    logic        [PW-1:0]            w_trunc;
    logic        [PW-1:0]            w_ph;
    logic        [PW-1:0]            w_cos_ph;
    logic signed [DATA_BITS_OUT-1:0] w_sin;
    logic signed [DATA_BITS_OUT-1:0] w_cos;

    assign w_sum   = {1'b0, r_acc} + AW1'(r_fcw_active);
    assign w_carry = w_sum[PHASE_ACC_BITS];
    assign w_xfer  = i_fcw_valid && r_fcw_ready;

`ifdef NCO_QUAD_PHASE_DITHER_EN
    localparam int                  DB   = PHASE_ACC_BITS - PW;
    localparam logic [PHASE_ACC_BITS-1:0] MASK = (PHASE_ACC_BITS'(1) << DB) - PHASE_ACC_BITS'(1);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_lfsr <= LFSR_SEED;
        else if (i_ena)
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end

    // Dither touches only the bits that truncation discards; r_acc itself is untouched.
    assign w_trunc = PW'((r_acc + (PHASE_ACC_BITS'(r_lfsr) & MASK)) >> DB);
`else
    assign w_trunc = PW'(r_acc >> (PHASE_ACC_BITS - PW));
`endif

    assign w_ph     = w_trunc + (PW'(i_phase_ofs) << (PW - PHASE_OFS_BITS));
    assign w_cos_ph = r_ph + QTR;

    nco_quarter_lut #(
        .LUT_ADDR_BITS (LUT_ADDR_BITS),
        .DATA_BITS_OUT (DATA_BITS_OUT)
    ) u_lut_sin (
        .i_phase (r_ph),
        .o_data  (w_sin)
    );

    nco_quarter_lut #(
        .LUT_ADDR_BITS (LUT_ADDR_BITS),
        .DATA_BITS_OUT (DATA_BITS_OUT)
    ) u_lut_cos (
        .i_phase (w_cos_ph),
        .o_data  (w_cos)
    );

    // FCW update FSM. Immediate mode never leaves ST_IDLE. Deferred mode parks the
    // word until a carry on an enabled edge or a sync, whichever comes first.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_fcw_ready  <= 1'b1;
            r_fcw_active <= '0;
            r_fcw_pend   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_xfer && UPDATE_ON_WRAP == 0) begin
                r_fcw_active <= i_fcw;
            end else if (w_xfer) begin
                r_fcw_pend  <= i_fcw;
                r_state     <= ST_PENDING;
                r_fcw_ready <= 1'b0;
            end
        end else if (i_sync || (i_ena && w_carry)) begin
            r_fcw_active <= r_fcw_pend;
            r_state      <= ST_IDLE;
            r_fcw_ready  <= 1'b1;
        end
    end

    // Accumulator -> phase register -> output register, advancing on enabled edges.
    // sync clears only the accumulator, even while disabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_wrap  <= 1'b0;
            r_ph    <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_vcnt  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_wrap <= i_ena && !i_sync && w_carry;
            if (i_sync)
                r_acc <= '0;
            else if (i_ena)
                r_acc <= w_sum[PHASE_ACC_BITS-1:0];
            if (i_ena) begin
                r_ph  <= w_ph;
                r_sin <= w_sin;
                r_cos <= w_cos;
                if (r_vcnt != 2'd2)
                    r_vcnt <= r_vcnt + 2'd1;
                else
                    r_valid <= 1'b1;
            end
        end
    end

    assign o_fcw_ready = r_fcw_ready;
    assign o_sin_out   = r_sin;
    assign o_cos_out   = r_cos;
    assign o_out_valid = r_valid;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_nco_quad.sv
// tb_nco_quad: scoreboard bench driving an immediate-update and a deferred-update nco_quad side by side.
module tb_nco_quad;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic [15:0]       fcw;
    logic              fcw_valid;
    logic [7:0]        ofs;
    logic              sync;
    logic              rdy_o   [2];
    logic signed [3:0] sin_o   [2];
    logic signed [3:0] cos_o   [2];
    logic              valid_o [2];
    logic              wrap_o  [2];

    typedef struct {
        int    dut;
        string nm;
        int    s;
        int    c;
        int    v;
        int    w;
        int    r;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int m_acc [2];
    int m_fa  [2];
    int m_fp  [2];
    bit m_pend[2];
    int m_ph  [2];
    int m_s   [2];
    int m_c   [2];
    int m_vc  [2];
    bit m_v   [2];
    bit m_w   [2];

    nco_quad u_dut0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (ena),
        .i_fcw       (fcw),
        .i_fcw_valid (fcw_valid),
        .o_fcw_ready (rdy_o[0]),
        .i_phase_ofs (ofs),
        .i_sync      (sync),
        .o_sin_out   (sin_o[0]),
        .o_cos_out   (cos_o[0]),
        .o_out_valid (valid_o[0]),
        .o_wrap      (wrap_o[0])
    );

    nco_quad #(.UPDATE_ON_WRAP(1)) u_dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (ena),
        .i_fcw       (fcw),
        .i_fcw_valid (fcw_valid),
        .o_fcw_ready (rdy_o[1]),
        .i_phase_ofs (ofs),
        .i_sync      (sync),
        .o_sin_out   (sin_o[1]),
        .o_cos_out   (cos_o[1]),
        .o_out_valid (valid_o[1]),
        .o_wrap      (wrap_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ideal sine at the centre of 256 phase bins, amplitude 7, rounded half away from zero.
    function automatic int ref_sin(input int p);
        return int'(7.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 256.0));
    endfunction

    task automatic chk(input string nm, input int d, input string fld, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d %s: got %0d required %0d", nm, d, fld, act, req);
        end
    endtask

    task automatic step(input int k);
        int sum;
        bit car;
        int fa_n;
        if (!rst_n) begin
            m_acc[k] = 0; m_fa[k] = 0; m_fp[k] = 0; m_pend[k] = 0; m_ph[k] = 0;
            m_s[k] = 0; m_c[k] = 0; m_vc[k] = 0; m_v[k] = 0; m_w[k] = 0;
            return;
        end
        sum  = m_acc[k] + m_fa[k];
        car  = ena && (sum >= (1 << 20));
        fa_n = m_fa[k];
        if (!m_pend[k]) begin
            if (fcw_valid) begin
                if (k == 0) fa_n = int'(fcw);
                else begin m_fp[k] = int'(fcw); m_pend[k] = 1; end
            end
        end else if (sync || car) begin
            fa_n = m_fp[k];
            m_pend[k] = 0;
        end
        m_w[k] = car && !sync;
        if (ena) begin
            m_s[k]  = ref_sin(m_ph[k]);
            m_c[k]  = ref_sin((m_ph[k] + 64) % 256);
            m_ph[k] = ((m_acc[k] >> 12) + int'(ofs)) % 256;
            if (m_vc[k] == 2) m_v[k] = 1; else m_vc[k]++;
        end
        m_acc[k] = sync ? 0 : (ena ? sum % (1 << 20) : m_acc[k]);
        m_fa[k]  = fa_n;
    endtask

    // One clock: model steps on the edge; expectations go to the scoreboard.
    // With hand set, the sample values come from the caller instead of the model.
    task automatic cyc(input string nm, input bit hand = 0, input int hs = 0, input int hc = 0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            step(k);
            sb.push_back('{k, nm, hand ? hs : m_s[k], hand ? hc : m_c[k],
                           int'(m_v[k]), int'(m_w[k]), int'(!m_pend[k])});
        end
        @(negedge clk);
    endtask

    task automatic run(input string nm, input int n);
        for (int i = 0; i < n; i++) cyc(nm);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, e.dut, "sin",   int'(sin_o[e.dut]),   e.s);
                chk(e.nm, e.dut, "cos",   int'(cos_o[e.dut]),   e.c);
                chk(e.nm, e.dut, "valid", int'(valid_o[e.dut]), e.v);
                chk(e.nm, e.dut, "wrap",  int'(wrap_o[e.dut]),  e.w);
                chk(e.nm, e.dut, "ready", int'(rdy_o[e.dut]),   e.r);
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; fcw = '0; fcw_valid = 1'b0; ofs = '0; sync = 1'b0;
        @(negedge clk);
        cyc("reset", 1, 0, 0);
        cyc("reset", 1, 0, 0);
        rst_n = 1'b1; ena = 1'b1;
        run("startup", 2);
        cyc("idle_phase0", 1, 0, 7);

        fcw = 16'h1000; fcw_valid = 1'b1;
        cyc("load_1000");
        fcw_valid = 1'b0; sync = 1'b1;
        cyc("sync_apply");
        sync = 1'b0;
        run("run_1000", 300);

        fcw = 16'h2000; fcw_valid = 1'b1;
        cyc("load_2000");
        fcw_valid = 1'b0;
        run("run_2000", 400);

        fcw = 16'h0000; fcw_valid = 1'b1; ofs = 8'h40;
        cyc("load_zero");
        fcw_valid = 1'b0; sync = 1'b1;
        cyc("sync_ofs");
        sync = 1'b0;
        cyc("ofs90");
        cyc("ofs90", 1, 7, 0);
        run("ofs90_hold", 4);

        ofs = 8'h00; fcw = 16'h3000; fcw_valid = 1'b1;
        cyc("load_3000");
        fcw_valid = 1'b0;
        run("run_3000", 20);
        ena = 1'b0; sync = 1'b1;
        cyc("sync_disabled");
        sync = 1'b0;
        cyc("disabled_hold");
        ena = 1'b1;
        cyc("after_sync");
        cyc("after_sync", 1, 0, 7);
        run("run_after_sync", 10);

        ena = 1'b0;
        run("frozen", 5);
        ena = 1'b1;
        run("thawed", 5);
        fcw = 16'h1000; fcw_valid = 1'b1;
        cyc("load_before_rst");
        fcw_valid = 1'b0; rst_n = 1'b0;
        cyc("mid_reset", 1, 0, 0);
        rst_n = 1'b1;
        run("restart", 2);
        cyc("restart_phase0", 1, 0, 7);
        for (int i = 0; i < 5; i++) cyc("restart_hold", 1, 0, 7);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/nco_quad.md
Name: nco_quad

Overview:
- Next-generation parametrised NCO for the GPS signal generator. Produces multi-bit signed sine/cosine from a quarter-wave table.
- Adds a frequency-word load handshake (immediate or phase-continuous update), a static phase offset, phase sync and a wrap strobe.
- Sits between the control/register interface and the carrier mixer. The existing 1-bit NCO remains for legacy paths.

Parameters:
- FCW_BITS, 16: frequency control word width; must be ≤ PHASE_ACC_BITS.
- PHASE_ACC_BITS, 20: phase accumulator width.
- LUT_ADDR_BITS, 6: quarter-wave table address bits; phase resolution is LUT_ADDR_BITS+2 bits.
- DATA_BITS_OUT, 4: signed two's-complement output width, ≥ 2.
- PHASE_OFS_BITS, 8: phase offset width, MSB-aligned to the truncated phase; must be ≤ LUT_ADDR_BITS+2.
- UPDATE_ON_WRAP, 0: 0 = apply new FCW at the next edge; 1 = defer until the next accumulator wrap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  advance enable; low freezes the accumulator and pipeline.
- fcw  in  FCW_BITS  new frequency word.
- fcw_valid  in  1  fcw offered.
- fcw_ready  out  1  block can accept fcw.
- phase_ofs  in  PHASE_OFS_BITS  static phase offset, in units of 2π/2^PHASE_OFS_BITS.
- sync  in  1  clear phase accumulator.
- sin_out  out  DATA_BITS_OUT  signed sine sample.
- cos_out  out  DATA_BITS_OUT  signed cosine sample.
- out_valid  out  1  sample valid.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

Behaviour:
- Reset (rst_n low at edge) clears the following:
  - acc = 0 and fcw_active = 0; any pending FCW is discarded.
  - Outputs: sin_out = 0, cos_out = 0, out_valid = 0, wrap = 0, fcw_ready = 1.
  - Reset mid-operation behaves identically.
- FCW update FSM has two states, IDLE and PENDING. fcw_ready = (state == IDLE). A transfer occurs when fcw_valid && fcw_ready.
  - UPDATE_ON_WRAP=0: the transfer loads fcw_active at that edge. The state stays IDLE.
  - UPDATE_ON_WRAP=1: the transfer captures fcw into fcw_pend and enters PENDING.
  - PENDING→IDLE on the first enabled edge where the accumulator carries out, or on sync. fcw_active takes fcw_pend at that edge.
  - Accumulator increments at that edge still use the old fcw_active.
  - Transfers are accepted regardless of ena. Deferred application requires ena.
- Accumulator, on an enabled edge: acc <= (acc + zero-extended fcw_active) mod 2^PHASE_ACC_BITS.
  - wrap is registered high for exactly that cycle when the sum carries out; otherwise 0.
  - sync has priority: acc <= 0 and wrap = 0, whether or not ena is high.
  - fcw_active = 0 holds the phase constant.
- Phase stage: P = acc[MSB -: LUT_ADDR_BITS+2] + (phase_ofs << (LUT_ADDR_BITS+2−PHASE_OFS_BITS)), mod 2^(LUT_ADDR_BITS+2).
  - Cosine phase = P + 2^LUT_ADDR_BITS, i.e. +90°.
- Quarter-wave fold:
  - q = top 2 bits; a = low LUT_ADDR_BITS bits; index = q[0] ? ~a : a.
  - mag = T[index]; result = q[1] ? −mag : mag.
- Table: T[i] = round((2^(DATA_BITS_OUT−1)−1)·sin(2π(i+0.5)/2^(LUT_ADDR_BITS+2))). The table never reaches −2^(DATA_BITS_OUT−1), so negation cannot overflow.
- Pipeline on enabled edges: acc register → phase register → output register.
  - Output reflects acc two enabled edges after it was registered.
  - out_valid: 0 after reset, 1 from the third enabled edge onward. It stays high while ena is low (outputs held).
  - sync does not drop out_valid.

Optional Feature:
- Macro NCO_QUAD_PHASE_DITHER_EN.
- When defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) is stepped on each enabled edge. It resets to 0xACE1.
  - Its low (PHASE_ACC_BITS−LUT_ADDR_BITS−2) bits are added to the accumulator value before truncation in the phase stage, with no change to acc itself. This reduces truncation spurs.
- When undefined, the LFSR is absent and the phase is truncated exactly as described above.

Decomposition:
- Package nco_pkg holds:
  - FSM state typedef (IDLE, PENDING).
  - Quadrant encoding constants.
  - LFSR seed and tap constant.
  - Constant function computing table entries from the parameters.
- Sub-module nco_quarter_lut: quarter-wave ROM plus fold/negate, instantiated twice (sin and cos).

Test Plan:
- Reset, then idle: with rst_n low for 2 cycles → all outputs 0, fcw_ready=1. Three enabled edges after release → out_valid=1, sin_out=T[0]=0, cos_out=+7 (defaults).
- Immediate load fcw=0x1000 with ena held high → wrap pulses every 256 cycles; sin_out period 256 samples; samples 0..255 match the golden model exactly.
- UPDATE_ON_WRAP=1, running at 0x1000, load 0x2000 mid-period → fcw_ready low until the next wrap; the period switches to 128 from that wrap onward with no phase discontinuity.
- phase_ofs=0x40 (90°) with fcw=0 → sin_out=+7, cos_out=T[0] negated fold = 0.
- sync asserted together with ena=0 and a pending FCW → acc=0 next edge, pending FCW applied, wrap=0, output phase 0 two enabled edges later.
- ena toggled 1-0-1 and rst_n pulsed mid-run → outputs frozen while ena=0; reset clears outputs, fcw_active and the pending word within one edge.
